// File: rtl/serialize_pkg.sv
// Shared definitions for the serializer: the count-field width helper and the
// wide-word field layout used by upstream packers and the bench.
package serialize_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic int nw(int num);
    return $clog2(num + 1);
  endfunction

  // Element i sits at elem_lsb(i, width); the active count sits directly above all elements.
  function automatic int elem_lsb(int i, int width);
    return i * width;
  endfunction

  function automatic int count_lsb(int num, int width);
    return num * width;
  endfunction

  localparam int DEF_NUM       = 4;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_COUNT_LSB = DEF_NUM * DEF_WIDTH;
  localparam int DEF_COUNT_W   = $clog2(DEF_NUM + 1);

endpackage

// File: rtl/serialize.sv
// Wide-to-narrow stream serializer: one NUM-element word in, one element per
// cycle out with eot on the last, bubble-free handover between words.
module serialize
  import serialize_pkg::*;
#(
  parameter  int NUM    = 4,
  parameter  int WIDTH  = 16,
  parameter  int ACTIVE = 0,
  localparam int CW     = $clog2(NUM),
  localparam int NW     = nw(NUM),
  localparam int DIN    = NUM * WIDTH + ((ACTIVE != 0) ? NW : 0),
  localparam int DOUT   = WIDTH + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [DIN-1:0]  din_data,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DOUT-1:0] dout_data
);

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        idx;
  logic [CW-1:0]        last_idx;
  logic [CW-1:0]        load_last;
  logic [NW-1:0]        cnt;
  logic [NUM*WIDTH-1:0] data_buf;
  logic                 busy;
  logic                 at_last;
  logic                 load;
  logic                 advance;
  logic                 load_empty;

  assign busy    = (state == BUSY);
  assign at_last = (idx == last_idx);
  // rst suppresses both handshakes even though din_ready reads 1 during reset
  assign load    = din_valid & din_ready & ~rst;
  assign advance = dout_valid & dout_ready & ~rst;

  always_comb begin
    cnt        = '0;
    load_last  = CW'(NUM - 1);
    load_empty = 1'b0;
    if (ACTIVE != 0) begin
      cnt = din_data[DIN-1 -: NW];
      if (cnt == '0) begin
        load_empty = 1'b1;
      end else if (int'(cnt) < NUM) begin
        load_last = CW'(int'(cnt) - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load on the last advance wins over returning to IDLE.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = load_empty ? IDLE : BUSY;
    end else if (advance && at_last) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    dout_valid = busy & ~rst;
    din_ready  = rst | ~busy | (dout_ready & at_last);
    dout_data  = {at_last, data_buf[idx*WIDTH +: WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      last_idx <= '0;
    end else if (load) begin
      data_buf <= din_data[NUM*WIDTH-1:0];
      idx      <= '0;
      last_idx <= load_last;
    end else if (advance && !at_last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule
